mux_scan_seq: RTL

- Upstream controller for the 8:1 single-bit channel mux.
- Drives the mux select lines s1/s2/s3 through channels 0..7 in turn.
- Waits a programmable settle time on each channel, then samples the mux output bit.
- Assembles the eight samples into one 8-bit word and hands it downstream over a valid/ready handshake.
- Supports single-shot and continuous scanning.

---
 rtl/mux_scan_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mux_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_seq
//  Purpose  : Scan controller for an 8:1 single-bit channel mux. It steps the
//             registered select lines through channels 0..7 and holds each
//             one for DWELL cycles. On the last cycle of each dwell it samples
//             mux_out. The eight samples form one word, which is offered
//             downstream over a valid/ready handshake. Scans can be
//             single-shot or continuous.
//  Ports    : clk, rst_n (sync, active-low)
//             start, cont, abort          - scan control
//             s1/s2/s3 (MSB..LSB), mux_out - mux select / returned bit
//             word, word_valid, word_ready - downstream handshake
//             busy                         - high outside IDLE
//             word_par, par_err, mux_out_par - only with MUX_SCAN_PARITY_EN
//  Options  : `define MUX_SCAN_PARITY_EN adds word parity and a parity check
//  Revision : 1.0 - initial release
// ============================================================================
module mux_scan_seq #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    input  logic       mux_out,
    output logic [7:0] word,
    output logic       word_valid,
    input  logic       word_ready,
`ifdef MUX_SCAN_PARITY_EN
    output logic       word_par,
    output logic       par_err,
    input  logic       mux_out_par,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Count value on which the dwell ends and the sample is taken.
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DWELL - 1);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    // Channels 0..6 only: the channel 7 sample goes straight into the word.
    logic [6:0]       r_shadow, w_shadow_nxt;
    logic [7:0]       r_word, w_word_nxt;
    logic             w_word_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sel    <= 3'd0;
            r_cnt    <= '0;
            r_shadow <= 7'd0;
            r_word   <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_word   <= w_word_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_word_nxt   = r_word;
        w_word_load  = 1'b0;
        case (r_state)
            IDLE: begin
                // abort wins over start, so the state stays IDLE.
                if (start && !abort) begin
                    w_state_nxt  = SETTLE;
                    w_sel_nxt    = 3'd0;
                    w_cnt_nxt    = '0;
                    w_shadow_nxt = 7'd0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    // The partial shadow is dropped. The last word is kept.
                    w_state_nxt = IDLE;
                    w_sel_nxt   = 3'd0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_last) begin
                    w_cnt_nxt = '0;
                    if (r_sel != 3'd7) begin
                        for (int i = 0; i < 7; i++) begin
                            if (r_sel == 3'(i)) begin
                                w_shadow_nxt[i] = mux_out;
                            end
                        end
                        w_sel_nxt = r_sel + 3'd1;
                    end else begin
                        w_word_nxt  = {mux_out, r_shadow};
                        w_word_load = 1'b1;
                        w_sel_nxt   = 3'd0;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = 3'd0;
                    w_cnt_nxt   = '0;
                end else if (word_ready) begin
                    // cont is looked at only here, on the handshake edge.
                    if (cont) begin
                        w_state_nxt  = SETTLE;
                        w_sel_nxt    = 3'd0;
                        w_cnt_nxt    = '0;
                        w_shadow_nxt = 7'd0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = 3'd0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign {s1, s2, s3} = r_sel;
    assign word         = r_word;
    assign word_valid   = (r_state == HOLD);
    assign busy         = (r_state != IDLE);

`ifdef MUX_SCAN_PARITY_EN
    logic r_word_par;
    logic r_par_err;
    logic w_par;

    assign w_par = ^w_word_nxt;

    // Parity is registered together with the word. par_err pulses on the
    // same edge that word_valid rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_par <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_par_err <= 1'b0;
            if (w_word_load) begin
                r_word_par <= w_par;
                r_par_err  <= (mux_out_par != w_par);
            end
        end
    end

    assign word_par = r_word_par;
    assign par_err  = r_par_err;
`else
    // No parity hardware in this build.
`endif

endmodule
`default_nettype wire
